// File: rtl/mul_acc_stage_pkg.sv
// -----------------------------------------------------------------------------
// mul_acc_stage_pkg
// Shared definitions for the multiply-accumulate stage and the multiplier it
// consumes from.
//   state_e     : control states of the accumulate stage (IDLE/ACCUM/EMIT)
//   ACC_W_DEF   : default accumulator / result width
//   CNT_W_DEF   : default width of the run-length field
//   PROD_W      : width of the multiplier product (8x8 -> 16)
// -----------------------------------------------------------------------------
package mul_acc_stage_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;
  localparam int PROD_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_e;

endpackage : mul_acc_stage_pkg

// File: rtl/mul_acc_stage_sat_add.sv
// -----------------------------------------------------------------------------
// sat_acc_add
// Combinational saturating adder: result = sat(acc + zero_ext(addend)).
// The sum is formed one bit wider than the accumulator. A carry out of the
// accumulator width clamps the result to all-ones and raises carry.
// Ports:
//   acc     in  ACC_W   current accumulator value
//   addend  in  ADD_W   unsigned value to add (zero-extended)
//   result  out ACC_W   saturated sum
//   carry   out 1       the unsaturated sum did not fit in ACC_W bits
// -----------------------------------------------------------------------------
module sat_acc_add
  import mul_acc_stage_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int ADD_W = PROD_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ADD_W-1:0] addend,
  output logic [ACC_W-1:0] result,
  output logic             carry
);

  logic [ACC_W:0] sum_wide;

  assign sum_wide = {1'b0, acc} + {{(ACC_W + 1 - ADD_W){1'b0}}, addend};
  assign carry    = sum_wide[ACC_W];
  assign result   = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

endmodule : sat_acc_add

// File: rtl/mul_acc_stage.sv
// -----------------------------------------------------------------------------
// mul_acc_stage
// Accumulates a programmable number of 16-bit multiplier products into a
// saturating ACC_W-bit accumulator and hands the result downstream.
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   begin a run (honoured only in IDLE)
//   len         in   CNT_W  products in the run, sampled with start
//   prod_valid  in   prod carries a valid product
//   prod_ready  out  product accepted this cycle (high only in ACCUM)
//   prod        in   PROD_W unsigned product
//   sum_valid   out  result available (high only in EMIT)
//   sum_ready   in   downstream accepts the result
//   sum         out  ACC_W accumulated result
//   overflow    out  run saturated; meaningful while sum_valid is high
//   busy        out  not in IDLE
// All outputs are decoded from registers only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module mul_acc_stage
  import mul_acc_stage_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum,
  output logic              overflow,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   len_q;
  logic               ovf_q;

  logic [ACC_W-1:0]   add_result;
  logic               add_carry;
  logic               xfer;
  logic               last_xfer;

  sat_acc_add #(
    .ACC_W (ACC_W),
    .ADD_W (PROD_W)
  ) u_add (
    .acc    (acc_q),
    .addend (prod),
    .result (add_result),
    .carry  (add_carry)
  );

  assign xfer      = prod_valid && (state_q == ACCUM);
  assign last_xfer = xfer && (cnt_q == (len_q - CNT_W'(1)));

  // State register.
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers sample pre-edge values; blocking assignments here would create
  // order-dependent simulation and sim/synthesis mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  // NOTE: state_d gets a default before the case so every path assigns it;
  // leaving any path unassigned in always_comb would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // A zero-length run skips accumulation and reports 0 directly.
          state_d = (len != '0) ? ACCUM : EMIT;
        end
      end
      ACCUM: begin
        if (last_xfer) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        // start in this cycle is deliberately ignored.
        if (sum_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: accumulator, product counter, latched length, sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q <= len;
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc_q <= add_result;
            cnt_q <= cnt_q + CNT_W'(1);
            // Sticky: once set it stays until the next accepted start.
            if (add_carry) begin
              ovf_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only. sum keeps its value after
  // the handshake until a new run clears the accumulator.
  assign prod_ready = (state_q == ACCUM);
  assign sum_valid  = (state_q == EMIT);
  assign busy       = (state_q != IDLE);
  assign sum        = acc_q;
  assign overflow   = ovf_q;

endmodule : mul_acc_stage

// File: tb/tb_mul_acc_stage.sv
// -----------------------------------------------------------------------------
// tb_mul_acc_stage
// Directed bench for mul_acc_stage. Two instances share every input: one at
// the default ACC_W = 24 and one at ACC_W = 16, so the saturation behaviour
// and the wide non-saturating result are checked from the same stimulus.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mul_acc_stage;

  localparam int CNT_W = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              prod_valid;
  logic [15:0]       prod;
  logic              sum_ready;

  logic              prod_ready_a, sum_valid_a, overflow_a, busy_a;
  logic [23:0]       sum_a;
  logic              prod_ready_b, sum_valid_b, overflow_b, busy_b;
  logic [15:0]       sum_b;

  int checks = 0;
  int errors = 0;

  mul_acc_stage #(.ACC_W(24), .CNT_W(CNT_W)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready_a),
    .prod       (prod),
    .sum_valid  (sum_valid_a),
    .sum_ready  (sum_ready),
    .sum        (sum_a),
    .overflow   (overflow_a),
    .busy       (busy_a)
  );

  mul_acc_stage #(.ACC_W(16), .CNT_W(CNT_W)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready_b),
    .prod       (prod),
    .sum_valid  (sum_valid_b),
    .sum_ready  (sum_ready),
    .sum        (sum_b),
    .overflow   (overflow_b),
    .busy       (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control outputs of both instances against the same expectation.
  task automatic check_ctl(input string tag, input logic pr, input logic sv, input logic bz);
    check({tag, " prod_ready_a"}, 32'(prod_ready_a), 32'(pr));
    check({tag, " prod_ready_b"}, 32'(prod_ready_b), 32'(pr));
    check({tag, " sum_valid_a"},  32'(sum_valid_a),  32'(sv));
    check({tag, " sum_valid_b"},  32'(sum_valid_b),  32'(sv));
    check({tag, " busy_a"},       32'(busy_a),       32'(bz));
    check({tag, " busy_b"},       32'(busy_b),       32'(bz));
  endtask

  task automatic check_res(input string tag, input logic [31:0] sa, input logic oa,
                           input logic [31:0] sb, input logic ob);
    check({tag, " sum_a"},      32'(sum_a),      sa);
    check({tag, " overflow_a"}, 32'(overflow_a), 32'(oa));
    check({tag, " sum_b"},      32'(sum_b),      sb);
    check({tag, " overflow_b"}, 32'(overflow_b), 32'(ob));
  endtask

  // Pulse start for one cycle; afterwards the DUT is in ACCUM (or EMIT).
  task automatic do_start(input logic [CNT_W-1:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  // Present one product for one cycle; it is accepted at the next edge.
  task automatic push(input logic [15:0] p);
    prod_valid = 1'b1;
    prod       = p;
    tick();
    prod_valid = 1'b0;
    prod       = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    prod_valid = 1'b0;
    prod       = '0;
    sum_ready  = 1'b0;

    // ---------------- reset values ----------------
    #12;
    check_ctl("reset", 1'b0, 1'b0, 1'b0);
    check_res("reset", 32'd0, 1'b0, 32'd0, 1'b0);
    #10 rst_n = 1'b1;
    tick();
    check_ctl("idle", 1'b0, 1'b0, 1'b0);

    // ---------------- T1: len 3, 100+200+300 back-to-back ----------------
    sum_ready = 1'b1;
    do_start(8'd3);
    check_ctl("t1 accum", 1'b1, 1'b0, 1'b1);
    push(16'd100);
    push(16'd200);
    check_ctl("t1 mid", 1'b1, 1'b0, 1'b1);
    push(16'd300);
    check_ctl("t1 emit", 1'b0, 1'b1, 1'b1);
    check_res("t1 emit", 32'd600, 1'b0, 32'd600, 1'b0);
    tick();
    check_ctl("t1 after", 1'b0, 1'b0, 1'b0);
    check_res("t1 after", 32'd600, 1'b0, 32'd600, 1'b0);

    // ---------------- T2: saturation on the 16-bit instance ----------------
    do_start(8'd2);
    push(16'd65025);
    check_res("t2 first", 32'd65025, 1'b0, 32'd65025, 1'b0);
    push(16'd65025);
    check_ctl("t2 emit", 1'b0, 1'b1, 1'b1);
    // 24-bit: 130050 = 0x1FC02 fits; 16-bit clamps to 0xFFFF and flags.
    check_res("t2 emit", 32'h1FC02, 1'b0, 32'hFFFF, 1'b1);
    tick();
    do_start(8'd1);
    push(16'd5);
    check_ctl("t2 next emit", 1'b0, 1'b1, 1'b1);
    check_res("t2 next", 32'd5, 1'b0, 32'd5, 1'b0);
    tick();

    // ---------------- T3: zero-length run ----------------
    do_start(8'd0);
    check_ctl("t3 emit", 1'b0, 1'b1, 1'b1);
    check_res("t3 emit", 32'd0, 1'b0, 32'd0, 1'b0);
    tick();
    check_ctl("t3 idle", 1'b0, 1'b0, 1'b0);

    // ---------------- T4: gaps, held result, ignored start ----------------
    sum_ready = 1'b0;
    do_start(8'd2);
    push(16'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ctl($sformatf("t4 gap%0d", i), 1'b1, 1'b0, 1'b1);
    end
    push(16'd9);
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      len   = 8'd4;
      check_ctl($sformatf("t4 hold%0d", i), 1'b0, 1'b1, 1'b1);
      check_res($sformatf("t4 hold%0d", i), 32'd16, 1'b0, 32'd16, 1'b0);
      tick();
    end
    // Handshake and start in the same cycle: start must be dropped.
    start     = 1'b1;
    sum_ready = 1'b1;
    tick();
    start = 1'b0;
    len   = '0;
    check_ctl("t4 idle", 1'b0, 1'b0, 1'b0);
    check_res("t4 idle", 32'd16, 1'b0, 32'd16, 1'b0);
    tick();
    check_ctl("t4 still idle", 1'b0, 1'b0, 1'b0);

    // ---------------- T5: asynchronous abort mid-run ----------------
    do_start(8'd4);
    push(16'd10);
    push(16'd20);
    check_res("t5 partial", 32'd30, 1'b0, 32'd30, 1'b0);
    prod_valid = 1'b1;
    prod       = 16'd1000;
    #2 rst_n = 1'b0;
    #1;
    check_ctl("t5 async", 1'b0, 1'b0, 1'b0);
    check_res("t5 async", 32'd0, 1'b0, 32'd0, 1'b0);
    prod_valid = 1'b0;
    prod       = '0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    check_ctl("t5 post", 1'b0, 1'b0, 1'b0);
    do_start(8'd1);
    push(16'd42);
    check_ctl("t5 emit", 1'b0, 1'b1, 1'b1);
    check_res("t5 emit", 32'd42, 1'b0, 32'd42, 1'b0);
    tick();
    check_ctl("t5 done", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mul_acc_stage
